sigma_gen_2: RTL and testbench
==============================

Name: sigma_gen_2

Overview:
- Consumes the 2x2 lower Cholesky factor L and produces the 2N+1 = 5 sigma points of a 2-state unscented transform: x, x ± gamma·L[:,j].
- Sits directly downstream of the 2x2 Cholesky stage.
- Emits points one per handshake to the propagation stage.
- All data is signed Q16.16, 32 bits.

Parameters:
- N, 2, state dimension; fixed, only 2 supported.
- FRAC_BITS, 16, fractional bits of the Q16.16 format.
- IDX_WIDTH, 3, width of sigma_idx.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- L  in  96  {L22, L21, L11}; L11 = bits [31:0], L21 = [63:32], L22 = [95:64]
- L_valid  in  1  L, x, gamma valid; sampled only when in_ready = 1
- x  in  64  mean {x2, x1}; x1 = bits [31:0]
- gamma  in  32  scale sqrt(N+lambda), Q16.16
- in_ready  out  1  block idle, will accept L_valid
- sigma  out  64  sigma point {s2, s1}; s1 = bits [31:0]
- sigma_idx  out  3  index 0..4 of the current point
- sigma_valid  out  1  sigma and sigma_idx valid
- sigma_ready  in  1  downstream accepts
- done  out  1  one-cycle pulse after the last point is accepted
- sat_flag  out  1  sticky per set: saturation occurred

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: in_ready = 1; sigma = 0; sigma_idx = 0; sigma_valid = 0; done = 0; sat_flag = 0. All internal registers cleared.
- States: S_IDLE, S_SCALE, S_EMIT.
- S_IDLE:
  - in_ready = 1.
  - On L_valid, at edge E0: capture L, x, gamma; clear sat_flag; scale counter = 0; go to S_SCALE; in_ready = 0.
  - L_valid when not in S_IDLE is ignored; no queuing.
- S_SCALE:
  - One product registered per cycle, in order: E1 g11 = gamma·L11, E2 g21 = gamma·L21, E3 g22 = gamma·L22.
  - Product: 64-bit signed multiply, result = bits [47:16], truncation (no rounding).
  - At E3 also: load sigma = x, sigma_idx = 0, sigma_valid = 1; go to S_EMIT.
  - First valid point is visible 3 cycles after capture.
- S_EMIT point order:
  - idx0: (x1, x2)
  - idx1: (x1+g11, x2+g21)
  - idx2: (x1, x2+g22)
  - idx3: (x1-g11, x2-g21)
  - idx4: (x1, x2-g22)
- Handshake:
  - Transfer occurs when sigma_valid & sigma_ready.
  - sigma and sigma_idx are held stable while sigma_valid & !sigma_ready.
  - With sigma_ready tied high: one point per cycle, idx0..idx4 on 5 consecutive cycles.
  - Next point is registered on the transfer edge.
- Final transfer (idx4):
  - sigma_valid = 0; done = 1 for exactly one cycle; state to S_IDLE.
  - in_ready = 1 in the same cycle as done.
  - L_valid coincident with the idx4 transfer is ignored.
- Add/sub: 32-bit signed (behaviour on overflow set by the optional feature).
- rst mid-operation: abort immediately to reset values; no done; the partial set is discarded.
- gamma = 0: idx1..idx4 all equal x; no special case.

Optional Feature:
- Macro: SIGMA_GEN_SAT_EN.
- Defined:
  - Product saturates to 0x7FFFFFFF / 0x80000000 when product bits [63:47] are not all equal.
  - Add/sub saturate on signed overflow.
  - Any saturation sets sat_flag; it stays set until the next capture or rst.
- Undefined:
  - Products truncate and add/sub wrap modulo 2^32.
  - sat_flag is tied 0; port retained.

Decomposition:
- Shared package chol_pkg:
  - Q_WIDTH = 32, FRAC_BITS = 16.
  - Q_MAX = 32'h7FFFFFFF, Q_MIN = 32'h80000000.
  - sigma state encoding (S_IDLE/S_SCALE/S_EMIT).
  - 2x2 packed-matrix field offsets, shared with the Cholesky stage.
- One sub-module: q16_addsub_sat.
  - Inputs: a, b, sub; output: y, ovf.
  - Purely combinational; saturation controlled by SIGMA_GEN_SAT_EN.
  - Instantiated twice, one per vector lane.

Test Plan:
- Nominal:
  - Stimulus: L11 = 0x00020000, L21 = 0x00010000, L22 = 0x00030000, x1 = 0x00010000, x2 = 0xFFFF0000, gamma = 0x00018000, sigma_ready = 1.
  - Required: sigma_valid rises 3 cycles after capture. Points {s1, s2}:
    - idx0: {00010000, FFFF0000}
    - idx1: {00040000, 00008000}
    - idx2: {00010000, 00038000}
    - idx3: {FFFE0000, FFFD8000}
    - idx4: {00010000, FFFA8000}
  - Then done is pulsed 1 cycle; sat_flag = 0.
- Backpressure:
  - Stimulus: nominal inputs; sigma_ready low for 4 cycles at idx2.
  - Required: sigma and idx held at idx2 unchanged; sequence resumes idx3, idx4; no point duplicated or dropped.
- Busy input:
  - Stimulus: second L_valid during S_SCALE, and again coincident with the idx4 transfer.
  - Required: both ignored; only one done pulse.
- Saturation:
  - Stimulus: x1 = 0x7FFF0000, L11 = 0x00020000, gamma = 0x00010000.
  - Required: idx1 s1 = 0x7FFFFFFF and sat_flag = 1 with SIGMA_GEN_SAT_EN; s1 = 0x80010000 and sat_flag = 0 without.
- Reset mid-operation:
  - Stimulus: rst asserted at idx1.
  - Required: next cycle sigma_valid = 0, done = 0, in_ready = 1.
  - A new nominal set then produces the correct 5 points.

Source files
------------

// File: rtl/chol_pkg.sv
// Shared definitions for the 2x2 Cholesky / sigma-point pipeline.
// Contents: Q16.16 format constants, sigma generator state encoding,
//           field offsets of the packed 2x2 lower-triangular matrix {L22, L21, L11}.
package chol_pkg;

  localparam int N         = 2;
  localparam int Q_WIDTH   = 32;
  localparam int FRAC_BITS = 16;
  localparam int IDX_WIDTH = 3;

  localparam logic [Q_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_WIDTH-1:0] Q_MIN = 32'h8000_0000;

  // Packed lower-triangular matrix layout, LSB first: L11, L21, L22.
  localparam int L11_LSB = 0;
  localparam int L21_LSB = Q_WIDTH;
  localparam int L22_LSB = 2 * Q_WIDTH;
  localparam int M_WIDTH = 3 * Q_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_EMIT  = 2'd2
  } sigma_state_e;

  function automatic logic [Q_WIDTH-1:0] mat_field(input logic [M_WIDTH-1:0] m,
                                                   input int lsb);
    return m[lsb +: Q_WIDTH];
  endfunction

endpackage

// File: rtl/q16_addsub_sat.sv
// Q16.16 signed add/subtract, purely combinational, one per vector lane.
// Ports: a, b operands; sub selects a-b (else a+b); y result; ovf signed overflow seen.
// With SIGMA_GEN_SAT_EN defined the result clamps to Q_MAX/Q_MIN on overflow; otherwise it wraps and ovf is 0.
module q16_addsub_sat
  import chol_pkg::*;
(
  input  logic [Q_WIDTH-1:0] a,
  input  logic [Q_WIDTH-1:0] b,
  input  logic               sub,
  output logic [Q_WIDTH-1:0] y,
  output logic               ovf
);

`ifdef SIGMA_GEN_SAT_EN
  // One guard bit: the result overflowed when the guard and sign bits disagree.
  logic [Q_WIDTH:0] ext;

  always_comb begin
    ext = sub ? ({a[Q_WIDTH-1], a} - {b[Q_WIDTH-1], b})
              : ({a[Q_WIDTH-1], a} + {b[Q_WIDTH-1], b});
    ovf = ext[Q_WIDTH] ^ ext[Q_WIDTH-1];
    y   = ovf ? (ext[Q_WIDTH] ? Q_MIN : Q_MAX) : ext[Q_WIDTH-1:0];
  end
`else
  always_comb begin
    y   = sub ? (a - b) : (a + b);
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/sigma_gen_2.sv
// Sigma-point generator for a 2-state unscented transform: x, x +/- gamma*L[:,j], 5 points.
// Ports: L/x/gamma with L_valid/in_ready in; sigma/sigma_idx with sigma_valid/sigma_ready out;
//        done pulses after the last point; sat_flag sticky per set (only with SIGMA_GEN_SAT_EN).
module sigma_gen_2
  import chol_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M_WIDTH-1:0]   L,
  input  logic                 L_valid,
  input  logic [2*Q_WIDTH-1:0] x,
  input  logic [Q_WIDTH-1:0]   gamma,
  output logic                 in_ready,
  output logic [2*Q_WIDTH-1:0] sigma,
  output logic [IDX_WIDTH-1:0] sigma_idx,
  output logic                 sigma_valid,
  input  logic                 sigma_ready,
  output logic                 done,
  output logic                 sat_flag
);

  sigma_state_e state, state_nxt;

  logic [M_WIDTH-1:0]   l_r;
  logic [2*Q_WIDTH-1:0] x_r;
  logic [Q_WIDTH-1:0]   gamma_r;
  logic [Q_WIDTH-1:0]   g11, g21, g22;
  logic [1:0]           cnt;

  logic                 xfer;
  logic                 last_xfer;

  assign xfer      = sigma_valid & sigma_ready;
  assign last_xfer = xfer & (sigma_idx == IDX_WIDTH'(4));

  // ---------------- scaling multiplier (one product per S_SCALE cycle) ----------------
  logic [Q_WIDTH-1:0]   l_sel;
  logic signed [63:0]   ga_ext, la_ext, prod;
  logic [Q_WIDTH-1:0]   prod_q;
  logic [15:0]          unused_prod_lo;

  always_comb begin
    case (cnt)
      2'd0:    l_sel = mat_field(l_r, L11_LSB);
      2'd1:    l_sel = mat_field(l_r, L21_LSB);
      default: l_sel = mat_field(l_r, L22_LSB);
    endcase
  end

  assign ga_ext = {{32{gamma_r[Q_WIDTH-1]}}, gamma_r};
  assign la_ext = {{32{l_sel[Q_WIDTH-1]}}, l_sel};
  assign prod   = ga_ext * la_ext;
  // Fractional bits below the Q16.16 LSB are dropped (truncation, no rounding).
  assign unused_prod_lo = prod[15:0];

`ifdef SIGMA_GEN_SAT_EN
  logic prod_sat;
  // Bits [63:47] must be a pure sign extension for the Q16.16 result to be exact.
  assign prod_sat = ~((&prod[63:47]) | ~(|prod[63:47]));
  assign prod_q   = prod_sat ? (prod[63] ? Q_MIN : Q_MAX) : prod[47:16];
`else
  logic [15:0] unused_prod_hi;
  assign unused_prod_hi = prod[63:48];
  assign prod_q         = prod[47:16];
`endif

  // ---------------- next-point lanes ----------------
  // The point after the current one is built from x and the scaled columns:
  // idx1/idx3 use column 1 (g11, g21), idx2/idx4 use column 2 (0, g22); idx3/idx4 subtract.
  logic [IDX_WIDTH-1:0] nidx;
  logic                 col1, lane_sub;
  logic [Q_WIDTH-1:0]   b1, b2, y1, y2;
  logic                 ovf1, ovf2;

  assign nidx     = sigma_idx + IDX_WIDTH'(1);
  assign col1     = (nidx == IDX_WIDTH'(1)) | (nidx == IDX_WIDTH'(3));
  assign lane_sub = (nidx >= IDX_WIDTH'(3));
  assign b1       = col1 ? g11 : '0;
  assign b2       = col1 ? g21 : g22;

  q16_addsub_sat u_lane1 (
    .a   (x_r[Q_WIDTH-1:0]),
    .b   (b1),
    .sub (lane_sub),
    .y   (y1),
    .ovf (ovf1)
  );

  q16_addsub_sat u_lane2 (
    .a   (x_r[2*Q_WIDTH-1:Q_WIDTH]),
    .b   (b2),
    .sub (lane_sub),
    .y   (y2),
    .ovf (ovf2)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (L_valid)        state_nxt = S_SCALE;
      S_SCALE: if (cnt == 2'd2)    state_nxt = S_EMIT;
      S_EMIT:  if (last_xfer)      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (state == S_IDLE);
  end

  // ---------------- datapath registers ----------------
`ifdef SIGMA_GEN_SAT_EN
  logic sat_r;
  assign sat_flag = sat_r;
`else
  logic unused_ovf;
  assign unused_ovf = ovf1 | ovf2;
  assign sat_flag   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      l_r         <= '0;
      x_r         <= '0;
      gamma_r     <= '0;
      g11         <= '0;
      g21         <= '0;
      g22         <= '0;
      cnt         <= '0;
      sigma       <= '0;
      sigma_idx   <= '0;
      sigma_valid <= 1'b0;
      done        <= 1'b0;
`ifdef SIGMA_GEN_SAT_EN
      sat_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (L_valid) begin
            l_r     <= L;
            x_r     <= x;
            gamma_r <= gamma;
            cnt     <= '0;
`ifdef SIGMA_GEN_SAT_EN
            sat_r   <= 1'b0;
`endif
          end
        end
        S_SCALE: begin
          case (cnt)
            2'd0:    g11 <= prod_q;
            2'd1:    g21 <= prod_q;
            default: g22 <= prod_q;
          endcase
          cnt <= cnt + 2'd1;
`ifdef SIGMA_GEN_SAT_EN
          if (prod_sat) sat_r <= 1'b1;
`endif
          if (cnt == 2'd2) begin
            sigma       <= x_r;
            sigma_idx   <= '0;
            sigma_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (last_xfer) begin
            sigma_valid <= 1'b0;
            done        <= 1'b1;
          end else if (xfer) begin
            sigma     <= {y2, y1};
            sigma_idx <= nidx;
`ifdef SIGMA_GEN_SAT_EN
            if (ovf1 | ovf2) sat_r <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_gen_2.sv
module tb_sigma_gen_2;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] L;
  logic        L_valid;
  logic [63:0] x;
  logic [31:0] gamma;
  logic        in_ready;
  logic [63:0] sigma;
  logic [2:0]  sigma_idx;
  logic        sigma_valid;
  logic        sigma_ready;
  logic        done;
  logic        sat_flag;

  sigma_gen_2 dut (
    .clk         (clk),
    .rst         (rst),
    .L           (L),
    .L_valid     (L_valid),
    .x           (x),
    .gamma       (gamma),
    .in_ready    (in_ready),
    .sigma       (sigma),
    .sigma_idx   (sigma_idx),
    .sigma_valid (sigma_valid),
    .sigma_ready (sigma_ready),
    .done        (done),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  // Points are {s2, s1}; L is {L22, L21, L11}; x is {x2, x1}.
  typedef struct packed {
    logic [95:0]       l;
    logic [63:0]       xv;
    logic [31:0]       g;
    logic [4:0][63:0]  pts;
    logic              sat;
  } vec_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] pt;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one full set. bp_len: cycles of sigma_ready low while idx2 is presented.
  // poke: extra L_valid during S_SCALE and coincident with the idx4 transfer.
  task automatic run_set(input int v, input int bp_len, input bit poke);
    int   stall;
    bit   seen;
    bit   finished;
    exp_t e;
    stall    = 0;
    seen     = 1'b0;
    finished = 1'b0;
    @(negedge clk);
    chk("in_ready_before", 64'(in_ready), 64'(1));
    L           = vecs[v].l;
    x           = vecs[v].xv;
    gamma       = vecs[v].g;
    L_valid     = 1'b1;
    sigma_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.idx = 3'(i);
      e.pt  = vecs[v].pts[i];
      sb.push_back(e);
    end
    for (int k = 1; k <= 60 && !finished; k++) begin
      @(negedge clk);
      L_valid = 1'b0;
      if (poke && k == 2) begin
        L_valid = 1'b1;
        x       = 64'h1234_0000_5678_0000;
      end
      if (sigma_valid && !seen) begin
        seen = 1'b1;
        chk("first_valid_latency", 64'(k - 1), 64'(3));
      end
      sigma_ready = 1'b1;
      if (sigma_valid && sigma_idx == 3'd2 && stall < bp_len) begin
        if (stall > 0) begin
          chk("bp_hold_idx", 64'(sigma_idx), 64'(2));
          chk("bp_hold_pt", sigma, vecs[v].pts[2]);
        end
        stall++;
        sigma_ready = 1'b0;
      end
      if (sigma_valid && sigma_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("sb_idx", 64'(sigma_idx), 64'(e.idx));
          chk("sb_pt", sigma, e.pt);
        end
        if (poke && sigma_idx == 3'd4) L_valid = 1'b1;
      end
      if (done) begin
        finished = 1'b1;
        chk("done_in_ready", 64'(in_ready), 64'(1));
        chk("done_valid_low", 64'(sigma_valid), 64'(0));
        chk("sat_flag", 64'(sat_flag), 64'(vecs[v].sat));
        chk("sb_left", 64'(sb.size()), 64'(0));
        L_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("idle_after_done", 64'(in_ready), 64'(1));
      end
    end
    if (!finished) begin
      chk("timeout_done", 64'(0), 64'(1));
      sb.delete();
    end
    if (bp_len > 0) chk("bp_stall_count", 64'(stall), 64'(bp_len));
  endtask

  initial begin
    // Nominal: gamma 1.5 -> g11 3.0, g21 1.5, g22 4.5
    vecs[0].l   = {32'h0003_0000, 32'h0001_0000, 32'h0002_0000};
    vecs[0].xv  = {32'hFFFF_0000, 32'h0001_0000};
    vecs[0].g   = 32'h0001_8000;
    vecs[0].pts = {{32'hFFFA_8000, 32'h0001_0000},
                   {32'hFFFD_8000, 32'hFFFE_0000},
                   {32'h0003_8000, 32'h0001_0000},
                   {32'h0000_8000, 32'h0004_0000},
                   {32'hFFFF_0000, 32'h0001_0000}};
    vecs[0].sat = 1'b0;
    // gamma = 0: every point equals x
    vecs[1].l   = {32'h0005_0000, 32'hFFFE_0000, 32'h0007_0000};
    vecs[1].xv  = {32'h0002_4000, 32'hFFF0_0000};
    vecs[1].g   = 32'h0000_0000;
    vecs[1].pts = {5{vecs[1].xv}};
    vecs[1].sat = 1'b0;
    // Truncation: gamma = 2^-16; 1.5*2^-16 -> 1 LSB, -1*2^-16 -> -1 LSB, 0.5*2^-16 -> 0
    vecs[2].l   = {32'h0000_8000, 32'hFFFF_0000, 32'h0001_8000};
    vecs[2].xv  = {32'h0000_0010, 32'h0000_0010};
    vecs[2].g   = 32'h0000_0001;
    vecs[2].pts = {{32'h0000_0010, 32'h0000_0010},
                   {32'h0000_0011, 32'h0000_000F},
                   {32'h0000_0010, 32'h0000_0010},
                   {32'h0000_000F, 32'h0000_0011},
                   {32'h0000_0010, 32'h0000_0010}};
    vecs[2].sat = 1'b0;
    // Lane-1 overflow at idx1: 0x7FFF0000 + 0x00020000
    vecs[3].l   = {32'h0000_0000, 32'h0000_0000, 32'h0002_0000};
    vecs[3].xv  = {32'h0000_0000, 32'h7FFF_0000};
    vecs[3].g   = 32'h0001_0000;
`ifdef SIGMA_GEN_SAT_EN
    vecs[3].pts = {{32'h0, 32'h7FFF_0000}, {32'h0, 32'h7FFD_0000},
                   {32'h0, 32'h7FFF_0000}, {32'h0, 32'h7FFF_FFFF},
                   {32'h0, 32'h7FFF_0000}};
    vecs[3].sat = 1'b1;
`else
    vecs[3].pts = {{32'h0, 32'h7FFF_0000}, {32'h0, 32'h7FFD_0000},
                   {32'h0, 32'h7FFF_0000}, {32'h0, 32'h8001_0000},
                   {32'h0, 32'h7FFF_0000}};
    vecs[3].sat = 1'b0;
`endif

    rst         = 1'b1;
    L           = '0;
    L_valid     = 1'b0;
    x           = '0;
    gamma       = '0;
    sigma_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_sigma", sigma, 64'(0));
    chk("rst_idx", 64'(sigma_idx), 64'(0));
    chk("rst_valid", 64'(sigma_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sat", 64'(sat_flag), 64'(0));

    for (int v = 0; v < 4; v++) run_set(v, 0, 1'b0);
    run_set(0, 4, 1'b0);   // backpressure at idx2 (also clears sat_flag after the overflow set)
    run_set(0, 0, 1'b1);   // busy-input pokes

    // Reset while idx1 is presented
    begin
      bit hit;
      hit = 1'b0;
      @(negedge clk);
      L           = vecs[0].l;
      x           = vecs[0].xv;
      gamma       = vecs[0].g;
      L_valid     = 1'b1;
      sigma_ready = 1'b1;
      for (int k = 0; k < 20 && !hit; k++) begin
        @(negedge clk);
        L_valid = 1'b0;
        if (sigma_valid && sigma_idx == 3'd1) begin
          hit = 1'b1;
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("midrst_valid", 64'(sigma_valid), 64'(0));
          chk("midrst_done", 64'(done), 64'(0));
          chk("midrst_in_ready", 64'(in_ready), 64'(1));
          chk("midrst_sigma", sigma, 64'(0));
        end
      end
      if (!hit) chk("timeout_idx1", 64'(0), 64'(1));
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'(0));
    end
    run_set(0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
